// File: rtl/mcu_clkcnt_bank.sv
// mcu_clkcnt_bank: bank of NCH free-running clock counters driven by per-channel
// command nibbles (SYNC / SAVE / CLR_OVF), with a 16-bit register bus for reading
// saved counter snapshots and per-channel status.
// Build option: define MCU_CLKCNT_SAVE_FIFO_EN to replace the single save register
// of each channel with a FIFO_DEPTH-entry save FIFO.
module mcu_clkcnt_bank #(
  parameter int unsigned NCH        = 8,
  parameter int unsigned CTR_W      = 48,
  parameter logic [15:0] BASE       = 16'h0100,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*4-1:0]       from_mcu,
  input  logic [15:0]            baddr,
  input  logic [15:0]            bwrdata,
  input  logic                   bwr,
  input  logic                   bstrobe,
  output logic [15:0]            brddata,
  output logic [NCH*CTR_W-1:0]   clkcnt,
  output logic [NCH-1:0]         sync_pulse
);

  localparam int unsigned NWORDS      = CTR_W / 16;
  localparam logic [3:0]  CMD_SYNC    = 4'h1;
  localparam logic [3:0]  CMD_SAVE    = 4'h2;
  localparam logic [3:0]  CMD_CLR_OVF = 4'h3;

  // Bus decode: each channel owns an 8-word window starting at BASE + 8*c.
  logic [15:0] bus_off;
  logic        bus_hit;
  logic [2:0]  bus_ch;
  logic [2:0]  bus_word;
  logic        ctrl_wr;

  assign bus_off  = baddr - BASE;
  assign bus_hit  = (bus_off < 16'(8 * NCH));
  assign bus_ch   = bus_off[5:3];
  assign bus_word = bus_off[2:0];
  assign ctrl_wr  = bstrobe & bwr & bus_hit & (bus_word == 3'd7);

  // Per-channel view used by the read mux.
  logic [CTR_W-1:0] head_w  [NCH];
  logic [3:0]       count_w [NCH];
  logic [NCH-1:0]   valid_w;
  logic [NCH-1:0]   ovf_w;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [3:0]       cmd_q;
      logic [CTR_W-1:0] cnt_q;
      logic             sync_q;
      logic             ch_sel;
      logic             pop_req;
      logic             clr_req;
      logic             save_req;

      assign ch_sel   = (bus_ch == 3'(gi));
      assign pop_req  = ctrl_wr & ch_sel & bwrdata[0];
      // A bus clear and a CLR_OVF command in the same cycle collapse into one clear.
      assign clr_req  = (ctrl_wr & ch_sel & bwrdata[1]) | (cmd_q == CMD_CLR_OVF);
      assign save_req = (cmd_q == CMD_SAVE);

      // Command register, free-running counter and registered sync pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmd_q  <= '0;
          cnt_q  <= '0;
          sync_q <= 1'b0;
        end else begin
          cmd_q <= from_mcu[4*gi +: 4];
          if (cmd_q == CMD_SYNC) begin
            cnt_q  <= '0;
            sync_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            sync_q <= 1'b0;
          end
        end
      end

      assign clkcnt[CTR_W*gi +: CTR_W] = cnt_q;
      assign sync_pulse[gi]            = sync_q;

`ifdef MCU_CLKCNT_SAVE_FIFO_EN
      localparam int unsigned AW = $clog2(FIFO_DEPTH);

      logic [CTR_W-1:0] mem_q [FIFO_DEPTH];
      logic [AW-1:0]    rd_ptr_q;
      logic [AW-1:0]    wr_ptr_q;
      logic [3:0]       count_q;
      logic             ovf_q;
      logic             do_pop;
      logic             fifo_full;
      logic             do_push;
      logic             drop;

      // A pop in the same cycle frees the slot, so a save into a full FIFO
      // succeeds when paired with a pop.
      assign do_pop    = pop_req & (count_q != 4'd0);
      assign fifo_full = (count_q == 4'(FIFO_DEPTH));
      assign do_push   = save_req & (~fifo_full | do_pop);
      assign drop      = save_req & fifo_full & ~do_pop;

      // Save FIFO storage, pointers, occupancy and sticky overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
            mem_q[k] <= '0;
          end
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
          ovf_q    <= 1'b0;
        end else begin
          if (do_push) begin
            mem_q[wr_ptr_q] <= cnt_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
          end
          if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
          if (do_push && !do_pop) begin
            count_q <= count_q + 4'd1;
          end else if (!do_push && do_pop) begin
            count_q <= count_q - 4'd1;
          end
          // A new overflow event wins over a simultaneous clear.
          if (drop) begin
            ovf_q <= 1'b1;
          end else if (clr_req) begin
            ovf_q <= 1'b0;
          end
        end
      end

      assign head_w[gi]  = mem_q[rd_ptr_q];
      assign count_w[gi] = count_q;
      assign valid_w[gi] = (count_q != 4'd0);
      assign ovf_w[gi]   = ovf_q;
`else
      logic [CTR_W-1:0] clksav_q;
      logic             valid_q;
      logic             ovf_q;
      logic             overwrite;

      // Overwriting an unread snapshot is an overflow unless it is popped in the same cycle.
      assign overwrite = save_req & valid_q & ~pop_req;

      // Single snapshot register with valid flag and sticky overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          clksav_q <= '0;
          valid_q  <= 1'b0;
          ovf_q    <= 1'b0;
        end else begin
          if (save_req) begin
            clksav_q <= cnt_q;
            valid_q  <= 1'b1;
          end else if (pop_req) begin
            valid_q  <= 1'b0;
          end
          if (overwrite) begin
            ovf_q <= 1'b1;
          end else if (clr_req) begin
            ovf_q <= 1'b0;
          end
        end
      end

      assign head_w[gi]  = clksav_q;
      assign count_w[gi] = {3'b000, valid_q};
      assign valid_w[gi] = valid_q;
      assign ovf_w[gi]   = ovf_q;
`endif
    end
  endgenerate

  // Read mux: saved-value words, status word, zero for everything else.
  logic [15:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (bus_hit) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (bus_ch == 3'(c)) begin
          if (bus_word == 3'd6) begin
            rd_word = {valid_w[c], ovf_w[c], 10'b0, count_w[c]};
          end else begin
            for (int w = 0; w < int'(NWORDS); w++) begin
              if (bus_word == 3'(w)) begin
                rd_word = head_w[c][16*w +: 16];
              end
            end
          end
        end
      end
    end
  end

  // Registered read data, updated only on read strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brddata <= '0;
    end else if (bstrobe && !bwr) begin
      brddata <= rd_word;
    end
  end

endmodule
